// File: rtl/cesa_pkg.sv
// Shared types and window carry helpers for the carry-estimating speculative adder.
package cesa_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    FIX,
    DONE
  } cesa_state_e;

  // Widest estimation window the helpers accept; callers zero-pad narrower windows.
  localparam int unsigned MAX_LB = 16;

  // Carry-out of the low n bit pairs with carry-in 0 (group generate).
  function automatic logic win_g(input logic [MAX_LB-1:0] a,
                                 input logic [MAX_LB-1:0] b,
                                 input int unsigned n);
    logic g;
    g = 1'b0;
    for (int unsigned i = 0; i < MAX_LB; i++) begin
      if (i < n) begin
        g = (a[i] & b[i]) | ((a[i] ^ b[i]) & g);
      end
    end
    return g;
  endfunction

  // True when every one of the low n bit pairs propagates (group propagate).
  function automatic logic win_p(input logic [MAX_LB-1:0] a,
                                 input logic [MAX_LB-1:0] b,
                                 input int unsigned n);
    logic p;
    p = 1'b1;
    for (int unsigned i = 0; i < MAX_LB; i++) begin
      if (i < n) begin
        p = p & (a[i] ^ b[i]);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/cesa_slice.sv
// One BLOCK-bit ripple slice; also estimates the carry it hands to the slice above
// from its own top two LOOKBACK-pair windows.
module cesa_slice
  import cesa_pkg::*;
#(
  parameter int unsigned BLOCK    = 8,
  parameter int unsigned LOOKBACK = 2
) (
  input  logic [BLOCK-1:0] a_i,
  input  logic [BLOCK-1:0] b_i,
  input  logic             cin_i,
  output logic [BLOCK-1:0] sum_o,
  output logic             cout_o,
  output logic             est_o
);

  logic [MAX_LB-1:0] w1_a, w1_b, w0_a, w0_b;

  always_comb begin
    logic c;
    c     = cin_i;
    sum_o = '0;
    for (int unsigned i = 0; i < BLOCK; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c;
      c        = (a_i[i] & b_i[i]) | ((a_i[i] ^ b_i[i]) & c);
    end
    cout_o = c;
  end

  always_comb begin
    w1_a = '0;
    w1_b = '0;
    w0_a = '0;
    w0_b = '0;
    w1_a[LOOKBACK-1:0] = a_i[BLOCK-1 -: LOOKBACK];
    w1_b[LOOKBACK-1:0] = b_i[BLOCK-1 -: LOOKBACK];
    w0_a[LOOKBACK-1:0] = a_i[BLOCK-LOOKBACK-1 -: LOOKBACK];
    w0_b[LOOKBACK-1:0] = b_i[BLOCK-LOOKBACK-1 -: LOOKBACK];
    // A fully propagating top window passes through whatever the window below produces.
    if (win_p(w1_a, w1_b, LOOKBACK)) begin
      est_o = win_g(w0_a, w0_b, LOOKBACK);
    end else begin
      est_o = win_g(w1_a, w1_b, LOOKBACK);
    end
  end

endmodule

// File: rtl/cesa_adder_seq.sv
// Carry-estimating speculative adder with valid/ready handshake, misprediction flag
// and optional block-serial exact repair.
module cesa_adder_seq
  import cesa_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned BLOCK    = 8,
  parameter int unsigned LOOKBACK = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             exact_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             spec_err_o
);

  localparam int unsigned NBLK = WIDTH / BLOCK;
  localparam int unsigned IDXW = $clog2(NBLK);

  cesa_state_e      state_q, state_d;
  logic             phase_q, phase_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             cin_q, cin_d;
  logic             exact_q, exact_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             err_q, err_d;

  logic [NBLK-1:0]  blk_cin, blk_cout, blk_est;
  logic [BLOCK-1:0] blk_sum [NBLK];
  logic [WIDTH-1:0] spec_sum;
  logic             spec_err;
  logic             unused_top_est;

  for (genvar k = 0; k < NBLK; k++) begin : g_slice
    cesa_slice #(
      .BLOCK    (BLOCK),
      .LOOKBACK (LOOKBACK)
    ) u_slice (
      .a_i    (a_q[k*BLOCK +: BLOCK]),
      .b_i    (b_q[k*BLOCK +: BLOCK]),
      .cin_i  (blk_cin[k]),
      .sum_o  (blk_sum[k]),
      .cout_o (blk_cout[k]),
      .est_o  (blk_est[k])
    );
  end

  assign unused_top_est = blk_est[NBLK-1];

  // During FIX the slice under repair takes the exact carry from the register
  // instead of its estimate; the other slices keep speculating harmlessly.
  always_comb begin
    blk_cin = {blk_est[NBLK-2:0], cin_q};
    for (int unsigned k = 1; k < NBLK; k++) begin
      if (state_q == FIX && idx_q == IDXW'(k)) begin
        blk_cin[k] = carry_q;
      end
    end
  end

  always_comb begin
    spec_sum = '0;
    for (int unsigned k = 0; k < NBLK; k++) begin
      spec_sum[k*BLOCK +: BLOCK] = blk_sum[k];
    end
    spec_err = |(blk_est[NBLK-2:0] ^ blk_cout[NBLK-2:0]);
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    exact_d = exact_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          a_d     = a_i;
          b_d     = b_i;
          cin_d   = cin_i;
          exact_d = exact_i;
          phase_d = 1'b0;
          state_d = EVAL;
        end
      end
      // Two cycles: capture the speculative pass, then decide on the registered flag.
      EVAL: begin
        if (!phase_q) begin
          sum_d   = spec_sum;
          cout_d  = blk_cout[NBLK-1];
          err_d   = spec_err;
          carry_d = blk_cout[0];
          phase_d = 1'b1;
        end else if (err_q && exact_q) begin
          idx_d   = IDXW'(1);
          state_d = FIX;
        end else begin
          state_d = DONE;
        end
      end
      FIX: begin
        for (int unsigned k = 1; k < NBLK; k++) begin
          if (idx_q == IDXW'(k)) begin
            sum_d[k*BLOCK +: BLOCK] = blk_sum[k];
            carry_d                 = blk_cout[k];
          end
        end
        if (idx_q == IDXW'(NBLK-1)) begin
          cout_d  = blk_cout[NBLK-1];
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      phase_q <= 1'b0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      exact_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      exact_q <= exact_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign sum_o       = sum_q;
  assign cout_o      = cout_q;
  assign spec_err_o  = err_q;

endmodule
